// File: rtl/audio_arb_pkg.sv
// ============================================================================
// Module      : audio_arb_pkg
// Description : Shared types and constants for the audio stream arbiter:
//               the arbiter FSM state enum, default sizing constants and
//               the source-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_arb_pkg;

  // Arbiter FSM states, explicitly one bit wide.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int AUDIO_DATA_SIZE = 28;
  localparam int AUDIO_MAX_SRC   = 8;

  // Width of a source index; never narrower than one bit.
  function automatic int src_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_stream_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Purely combinational round-robin picker. Finds the first
//               requester scanning upward from last_grant+1 with wrap.
// Ports       : req        in  NUM_SRC  request vector
//               last_grant in  SRC_W    most recently granted index
//               found      out 1        at least one request present
//               idx        out SRC_W    index of the chosen requester
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_SRC = 2,
  parameter int SRC_W   = 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   last_grant,
  output logic               found,
  output logic [SRC_W-1:0]   idx
);

  localparam int SW1 = SRC_W + 1;

  logic [SW1-1:0]           w_start;    // last_grant + 1
  logic [2*NUM_SRC-1:0]     w_dbl;
  logic [2*NUM_SRC-1:0]     w_shift;
  logic [NUM_SRC-1:0]       w_rot;      // requests rotated so bit 0 is last_grant+1
  logic [NUM_SRC-1:0]       w_onehot;   // lowest set bit of w_rot
  logic [SRC_W-1:0]         w_ofs;      // position of that bit in rotated order
  logic [SW1-1:0]           w_sum;
  logic [SRC_W-1:0][NUM_SRC-1:0] w_bitsel;

  assign w_start  = {1'b0, last_grant} + SW1'(1);
  assign w_dbl    = {req, req};
  assign w_shift  = w_dbl >> w_start;
  assign w_rot    = w_shift[NUM_SRC-1:0];
  assign w_onehot = w_rot & (~w_rot + NUM_SRC'(1));

  // One-hot to binary: bit b of the offset is the OR of all one-hot
  // positions whose index has bit b set.
  for (genvar b = 0; b < SRC_W; b++) begin : g_enc_bit
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_enc_src
      assign w_bitsel[b][i] = (((i >> b) & 1) == 1) ? w_onehot[i] : 1'b0;
    end
    assign w_ofs[b] = |w_bitsel[b];
  end

  // Undo the rotation: (last_grant + 1 + offset) mod NUM_SRC.
  assign w_sum = w_start + {1'b0, w_ofs};
  assign idx   = (w_sum >= SW1'(NUM_SRC)) ? SRC_W'(w_sum - SW1'(NUM_SRC))
                                          : SRC_W'(w_sum);
  assign found = |req;

endmodule

`default_nettype wire

// File: rtl/audio_stream_arbiter.sv
// ============================================================================
// Module      : audio_stream_arbiter
// Description : Round-robin arbiter sharing one audio sample stream between
//               NUM_SRC producers, granting bursts of up to BURST samples
//               through a single registered valid/ready output stage.
// Ports       : clk, reset_n (async, active low), enable,
//               src_valid/src_data/src_ready   producer side
//               out_valid/out_data/out_src/out_ready   bridge side
//               grant_active, grant_idx   grant status
// Macros      : ARB_TAG_EN - when defined, the top SRC_W bits of out_data
//               carry the source index instead of the sample's top bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_stream_arbiter
  import audio_arb_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int DATA_SIZE = AUDIO_DATA_SIZE,
  parameter int BURST     = 4,
  parameter int SRC_W     = src_w(NUM_SRC)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*DATA_SIZE-1:0] src_data,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic                         out_valid,
  output logic [DATA_SIZE-1:0]         out_data,
  output logic [SRC_W-1:0]             out_src,
  input  logic                         out_ready,
  output logic                         grant_active,
  output logic [SRC_W-1:0]             grant_idx
);

  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);

  arb_state_t             state;
  arb_state_t             next_state;
  logic [SRC_W-1:0]       last_grant;
  logic [CNT_W-1:0]       burst_cnt;

  logic                   pick_found;
  logic [SRC_W-1:0]       pick_idx;
  logic [DATA_SIZE-1:0]   src_word [NUM_SRC];
  logic [DATA_SIZE-1:0]   sel_word;
  logic [DATA_SIZE-1:0]   out_word;
  logic                   cur_valid;
  logic                   room;
  logic                   hs;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_word[i] = src_data[i*DATA_SIZE +: DATA_SIZE];
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_pick (
    .req        (src_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  assign sel_word  = src_word[grant_idx];
  assign cur_valid = src_valid[grant_idx];
  // Output stage can take a sample if empty or draining this cycle.
  assign room      = !out_valid || out_ready;
  assign hs        = (state == XFER) && cur_valid && room;

`ifdef ARB_TAG_EN
  assign out_word = {grant_idx, sel_word[DATA_SIZE-SRC_W-1:0]};
`else
  assign out_word = sel_word;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (enable && pick_found) next_state = XFER;
      XFER: if (!cur_valid || (hs && burst_cnt == '0)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic; src_ready has a combinational path from out_ready.
  always_comb begin
    src_ready    = '0;
    grant_active = 1'b0;
    if (state == XFER) begin
      grant_active         = 1'b1;
      src_ready[grant_idx] = room;
    end
  end

  // Grant bookkeeping and burst counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_idx  <= '0;
      last_grant <= SRC_W'(NUM_SRC - 1);
      burst_cnt  <= '0;
    end else if (state == IDLE) begin
      if (enable && pick_found) begin
        grant_idx  <= pick_idx;
        last_grant <= pick_idx;
        burst_cnt  <= BURST_LAST;
      end
    end else if (hs && burst_cnt != '0) begin
      burst_cnt <= burst_cnt - CNT_W'(1);
    end
  end

  // Registered output stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (hs) begin
      out_valid <= 1'b1;
      out_data  <= out_word;
      out_src   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_audio_stream_arbiter.sv
// ============================================================================
// Module      : tb_audio_stream_arbiter
// Description : Self-checking bench for audio_stream_arbiter (NUM_SRC=2,
//               BURST=4, DATA_SIZE=28): reset vector table, directed
//               sequences and a randomized run against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_stream_arbiter;

  localparam int N  = 2;
  localparam int DW = 28;
  localparam int BL = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            enable = 1'b0;
  logic [N-1:0]    src_valid = '0;
  logic [N*DW-1:0] src_data = '0;
  logic [N-1:0]    src_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [0:0]      out_src;
  logic            out_ready = 1'b0;
  logic            grant_active;
  logic [0:0]      grant_idx;

  audio_stream_arbiter #(.NUM_SRC(N), .DATA_SIZE(DW), .BURST(BL)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .grant_active(grant_active), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    enable    = 1'b0;
    src_valid = '0;
    src_data  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Expected bridge word for a sample from source s.
  function automatic logic [DW-1:0] word(input logic [DW-1:0] d, input int s);
    logic [31:0] sv;
    sv = 32'(s);
`ifdef ARB_TAG_EN
    return {sv[0], d[DW-2:0]};
`else
    return (sv[0] === 1'bx) ? '0 : d;
`endif
  endfunction

  function automatic logic [DW-1:0] data_of(input logic [N*DW-1:0] d, input int s);
    logic [N*DW-1:0] t;
    t = d >> (s * DW);
    return t[DW-1:0];
  endfunction

  function automatic logic bit_of(input logic [N-1:0] v, input int s);
    logic [N-1:0] t;
    t = v >> s;
    return t[0];
  endfunction

  typedef struct {
    logic       rdy;
    logic       e_ga;
    logic       e_gi;
    logic [1:0] e_sr;
    logic       e_ov;
    logic       e_os;
    logic [27:0] e_od;
  } vec_t;

  vec_t tbl[10];

  // Reference model state
  bit          m_g;
  int          m_gi, m_left, m_last, m_os;
  bit          m_ov;
  logic [DW-1:0] m_od;

  task automatic model_reset();
    m_g = 0; m_gi = 0; m_left = 0; m_last = N - 1;
    m_ov = 0; m_od = '0; m_os = 0;
  endtask

  task automatic model_step();
    bit hs;
    hs = m_g && bit_of(src_valid, m_gi) && (!m_ov || out_ready);
    if (hs) begin
      m_ov = 1; m_od = word(data_of(src_data, m_gi), m_gi); m_os = m_gi;
    end else if (out_ready) m_ov = 0;
    if (m_g) begin
      if (!bit_of(src_valid, m_gi)) m_g = 0;
      else if (hs) begin
        m_left--;
        if (m_left == 0) m_g = 0;
      end
    end else if (enable && (|src_valid)) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!m_g && bit_of(src_valid, c)) begin
          m_g = 1; m_gi = c; m_last = c; m_left = BL;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] seqbits;
    int n, c0, c1, h0, h1, p, cyc;
    logic [DW-1:0] got[$];
    logic [DW-1:0] held;
    bit done;

    // ---------------- reset state ----------------
    #1;
    chk("rst_ready", 32'(src_ready), 0);
    chk("rst_ctrl", {grant_active, grant_idx, out_valid, out_src}, 0);
    chk("rst_data", 32'(out_data), 0);

    // ---------------- table: first grants ----------------
    tbl[0] = '{1, 0, 0, 2'b00, 0, 0, 28'h0};
    tbl[1] = '{1, 1, 0, 2'b01, 0, 0, 28'h0};
    tbl[2] = '{1, 1, 0, 2'b01, 1, 0, 28'h1234567};
    tbl[3] = '{1, 1, 0, 2'b01, 1, 0, 28'h1234567};
    tbl[4] = '{1, 1, 0, 2'b01, 1, 0, 28'h1234567};
    tbl[5] = '{1, 0, 0, 2'b00, 1, 0, 28'h1234567};
    tbl[6] = '{1, 1, 1, 2'b10, 0, 0, 28'h1234567};
    tbl[7] = '{1, 1, 1, 2'b10, 1, 1, 28'hF654321};
    tbl[8] = '{0, 1, 1, 2'b00, 1, 1, 28'hF654321};
    tbl[9] = '{1, 1, 1, 2'b10, 1, 1, 28'hF654321};
    do_reset();
    for (int r = 0; r < 10; r++) begin
      enable = 1; src_valid = 2'b11; out_ready = tbl[r].rdy;
      src_data = {28'hF654321, 28'h1234567};
      #1;
      chk($sformatf("tbl%0d_ga", r), 32'(grant_active), 32'(tbl[r].e_ga));
      chk($sformatf("tbl%0d_gi", r), 32'(grant_idx), 32'(tbl[r].e_gi));
      chk($sformatf("tbl%0d_sr", r), 32'(src_ready), 32'(tbl[r].e_sr));
      chk($sformatf("tbl%0d_ov", r), 32'(out_valid), 32'(tbl[r].e_ov));
      chk($sformatf("tbl%0d_os", r), 32'(out_src), 32'(tbl[r].e_os));
      chk($sformatf("tbl%0d_od", r), 32'(out_data), 32'(tbl[r].e_od));
      tick();
    end

    // ---------------- fairness: 32 samples ----------------
    do_reset();
    n = 0; c0 = 0; seqbits = 0;
    for (int k = 0; k < 200 && n < 32; k++) begin
      enable = 1; src_valid = 2'b11; out_ready = 1;
      #1;
      if (out_valid) begin
        seqbits[n] = out_src[0];
        if (out_src == 0) c0++;
        n++;
      end
      tick();
    end
    chk("fair_samples", 32'(n), 32);
    chk("fair_order", seqbits, 32'hF0F0F0F0);
    chk("fair_count0", 32'(c0), 16);

    // ---------------- early release ----------------
    do_reset();
    n = 0; h0 = 0; h1 = 0; seqbits = 0;
    for (int k = 0; k < 200 && n < 10; k++) begin
      enable = 1; out_ready = 1;
      src_valid = {h1 < 4, (h0 < 2) || (h1 >= 4)};
      #1;
      if (src_ready[0] && src_valid[0]) h0++;
      if (src_ready[1] && src_valid[1]) h1++;
      if (out_valid) begin seqbits[n] = out_src[0]; n++; end
      tick();
    end
    chk("early_samples", 32'(n), 10);
    chk("early_order", seqbits, 32'h3C);

    // ---------------- backpressure ----------------
    do_reset();
    p = 0; got.delete(); held = '0;
    for (cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      enable = 1;
      src_valid = {1'b0, p < 4};
      src_data = {28'h0, 28'(28'hA000001 + p)};
      out_ready = !(cyc >= 4 && cyc < 9);
      #1;
      if (out_valid && !out_ready) begin
        if (cyc == 4) held = out_data;
        chk("bp_ready_low", 32'(src_ready), 0);
        chk("bp_hold", {out_src, 3'b0, out_data}, {1'b0, 3'b0, held});
      end
      if (out_valid && out_ready) got.push_back(out_data);
      if (src_ready[0] && src_valid[0]) p++;
      tick();
    end
    chk("bp_count", 32'(got.size()), 4);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("bp_seq%0d", i), 32'(got[i]), 32'(28'hA000001 + i));

    // ---------------- enable gating ----------------
    do_reset();
    c0 = 0; c1 = 0;
    for (int k = 0; k < 15; k++) begin
      enable = (k < 2); src_valid = 2'b11; out_ready = 1;
      #1;
      if (out_valid && out_src == 0) c0++;
      if (out_valid && out_src == 1) c1++;
      tick();
    end
    chk("en_burst0", 32'(c0), 4);
    chk("en_noburst1", 32'(c1), 0);
    chk("en_idle", 32'(grant_active), 0);
    done = 0;
    for (int k = 0; k < 5 && !done; k++) begin
      enable = 1; #1;
      done = grant_active;
      if (!done) tick();
    end
    chk("en_regrant", 32'(done), 1);
    chk("en_regrant_idx", 32'(grant_idx), 1);

    // ---------------- all-ones sample through both sources ----------------
    do_reset();
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      enable = 1; src_valid = 2'b01; out_ready = 1;
      src_data = {28'h0, 28'hFFFFFFF};
      #1; done = out_valid;
      if (!done) tick();
    end
`ifdef ARB_TAG_EN
    chk("ones_src0", 32'(out_data), 32'h7FFFFFF);
`else
    chk("ones_src0", 32'(out_data), 32'hFFFFFFF);
`endif
    do_reset();
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      enable = 1; src_valid = 2'b10; out_ready = 1;
      src_data = {28'hFFFFFFF, 28'h0};
      #1; done = out_valid;
      if (!done) tick();
    end
    chk("ones_src1", 32'(out_data), 32'hFFFFFFF);
    chk("ones_src1_os", 32'(out_src), 1);

    // ---------------- randomized vs. reference model ----------------
    do_reset();
    model_reset();
    for (int k = 0; k < 800; k++) begin
      logic [1:0] e_sr;
      enable    = ($urandom_range(0, 7) != 0);
      src_valid = 2'($urandom_range(0, 3));
      src_data  = {28'($urandom), 28'($urandom)};
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      e_sr = (m_g && (!m_ov || out_ready)) ? (2'b01 << m_gi) : 2'b00;
      chk("rnd_ctrl", {grant_active, grant_idx, src_ready, out_valid, out_src},
          {m_g, 1'(m_gi), e_sr, m_ov, 1'(m_os)});
      chk("rnd_data", 32'(out_data), 32'(m_od));
      if (k == 400) begin
        // Asynchronous reset mid-run, between clock edges.
        reset_n = 0;
        #1;
        chk("arst_ctrl", {grant_active, grant_idx, src_ready, out_valid, out_src}, 0);
        chk("arst_data", 32'(out_data), 0);
        model_reset();
        tick();
        reset_n = 1;
      end else begin
        model_step();
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
